// File: rtl/inst_cache.sv
// -----------------------------------------------------------------------------
// inst_cache
//   Direct-mapped instruction cache with 2^INDEX_BITS one-word lines.
//   A hit returns the word one cycle after the request is accepted. A miss
//   issues a single-word fetch to the memory controller. The word comes back
//   in the cycle after the controller's MC_done pulse, and the line is filled
//   at the same time.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   rdy           global ready; when low the cache freezes
//   clr           pipeline flush; abandons an outstanding miss, keeps lines
//   IF_valid      fetch request from the fetch stage
//   IF_pc         fetch address (word aligned, pc[1:0] ignored)
//   IF_ready      request accepted this cycle (IDLE and rdy)
//   IF_inst_valid one-cycle pulse qualifying IF_inst
//   IF_inst       returned instruction; holds its value between pulses
//   MC_req        fetch request to the memory controller
//   MC_addr       fetch address to the memory controller
//   MC_done       one-cycle pulse, MC_inst valid
//   MC_inst       instruction word from the memory controller
// -----------------------------------------------------------------------------
module inst_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        IF_valid,
    input  logic [31:0] IF_pc,
    output logic        IF_ready,
    output logic        IF_inst_valid,
    output logic [31:0] IF_inst,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_inst
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Line storage. Only the valid bits are reset, so tag and data can map
    // onto plain RAM.
    logic [LINES-1:0]    valid_reg;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    // Address decode for the incoming request.
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    assign req_index = IF_pc[INDEX_BITS+1:2];
    assign req_tag   = IF_pc[31:INDEX_BITS+2];

    // The outstanding miss is described by MC_addr, which stays frozen for the
    // whole miss, so the fill reuses it rather than keeping a second copy.
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;
    assign miss_index = MC_addr[INDEX_BITS+1:2];
    assign miss_tag   = MC_addr[31:INDEX_BITS+2];

    logic hit;
    assign hit = valid_reg[req_index] && (tag_mem[req_index] == req_tag);

    // Actions decided for this edge.
    logic do_hit;
    logic do_miss;
    logic do_fill;

    assign IF_ready = (state_reg == IDLE) && rdy;

    // -------------------------------------------------------------------------
    // Next-state logic. clr wins over everything, including rdy. With rdy low
    // nothing moves.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_fill    = 1'b0;
        if (clr) begin
            state_next = IDLE;
        end else if (rdy) begin
            case (state_reg)
                IDLE: begin
                    if (IF_valid) begin
                        if (hit) begin
                            do_hit = 1'b1;
                        end else begin
                            do_miss    = 1'b1;
                            state_next = MISS;
                        end
                    end
                end
                MISS: begin
                    if (MC_done) begin
                        do_fill    = 1'b1;
                        state_next = FILL;
                    end
                end
                FILL: begin
                    // The word is being presented this cycle. The next
                    // request is taken from IDLE.
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs and valid bits.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg     <= '0;
            MC_req        <= 1'b0;
            MC_addr       <= 32'd0;
            IF_inst_valid <= 1'b0;
            IF_inst       <= 32'd0;
        end else begin
            // The pulse comes only from a hit or a fill. Stalls and flushes
            // both leave it low.
            IF_inst_valid <= do_hit | do_fill;
            if (do_hit) begin
                IF_inst <= data_mem[req_index];
            end
            if (do_miss) begin
                MC_req  <= 1'b1;
                MC_addr <= IF_pc;
            end
            if (do_fill) begin
                MC_req               <= 1'b0;
                valid_reg[miss_index] <= 1'b1;
                IF_inst              <= MC_inst;
            end
            if (clr) begin
                MC_req <= 1'b0;
            end
        end
    end

    // Tag and data write port. A reset in the same cycle abandons the fill.
    always_ff @(posedge clk) begin
        if (!rst && do_fill) begin
            tag_mem[miss_index]  <= miss_tag;
            data_mem[miss_index] <= MC_inst;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// -----------------------------------------------------------------------------
// tb_inst_cache
//   Directed bench for inst_cache. The stimulus pushes each expected
//   instruction into a queue. A monitor pops an entry on every IF_inst_valid
//   pulse and compares it with IF_inst.
// -----------------------------------------------------------------------------
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        IF_valid;
    logic [31:0] IF_pc;
    logic        IF_ready;
    logic        IF_inst_valid;
    logic [31:0] IF_inst;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done;
    logic [31:0] MC_inst;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    inst_cache #(.INDEX_BITS(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .clr           (clr),
        .IF_valid      (IF_valid),
        .IF_pc         (IF_pc),
        .IF_ready      (IF_ready),
        .IF_inst_valid (IF_inst_valid),
        .IF_inst       (IF_inst),
        .MC_req        (MC_req),
        .MC_addr       (MC_addr),
        .MC_done       (MC_done),
        .MC_inst       (MC_inst)
    );

    always #5 clk = ~clk;

    // Memory image behind the controller.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_1000: mem_word = 32'h0050_0093;
            32'h0000_1004: mem_word = 32'h0010_0113;
            32'h0000_1008: mem_word = 32'h0020_8193;
            32'h0000_100C: mem_word = 32'h0031_0233;
            32'h0000_1010: mem_word = 32'h0041_82B3;
            32'h0000_1014: mem_word = 32'h0052_0333;
            32'h0000_1018: mem_word = 32'h0062_83B3;
            32'h0000_101C: mem_word = 32'h0073_0433;
            32'h0000_1100: mem_word = 32'h00A0_0113;
            default:       mem_word = 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end else begin
            $display("ok   %s: 0x%08h", name, actual);
        end
    endtask

    // Monitor: every pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && IF_inst_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: got IF_inst=0x%08h, expected no pulse", IF_inst);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (IF_inst !== e) begin
                    failures++;
                    $display("FAIL inst_pulse: got 0x%08h, expected 0x%08h", IF_inst, e);
                end else begin
                    $display("ok   inst_pulse: 0x%08h", IF_inst);
                end
            end
        end
    end

    // Present a request and hold it until it is accepted. The task returns
    // 1 time unit after the accepting edge.
    task automatic fetch(input logic [31:0] pc, input bit is_hit);
        int guard;
        guard    = 0;
        IF_valid = 1'b1;
        IF_pc    = pc;
        while (!IF_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            failures++;
            $display("FAIL fetch_accept: got IF_ready=0 for 100 cycles, expected 1");
        end
        if (is_hit) exp_q.push_back(mem_word(pc));
        @(posedge clk);
        #1;
        IF_valid = 1'b0;
        IF_pc    = 32'hFFFF_FFF0;
        $display("fetch pc=0x%08h hit=%0d", pc, is_hit);
    endtask

    // Act as the memory controller for an outstanding miss. The address must
    // stay stable for lat cycles. Then MC_done pulses and the word must
    // appear in the following cycle.
    task automatic serve(input logic [31:0] addr, input int lat);
        chk("miss_req", {31'd0, MC_req}, 32'd1);
        chk("miss_addr", MC_addr, addr);
        for (int i = 0; i < lat; i++) begin
            @(posedge clk);
            #1;
            chk("miss_req_hold", {31'd0, MC_req}, 32'd1);
            chk("miss_addr_hold", MC_addr, addr);
        end
        exp_q.push_back(mem_word(addr));
        MC_done = 1'b1;
        MC_inst = mem_word(addr);
        @(posedge clk);
        #1;
        MC_done = 1'b0;
        MC_inst = 32'h5A5A_5A5A;
        chk("req_drop", {31'd0, MC_req}, 32'd0);
        chk("fill_pulse", {31'd0, IF_inst_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("fill_one_cycle", {31'd0, IF_inst_valid}, 32'd0);
        chk("back_to_idle", {31'd0, IF_ready}, 32'd1);
    endtask

    // Hard time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        clr      = 1'b0;
        IF_valid = 1'b0;
        IF_pc    = 32'd0;
        MC_done  = 1'b0;
        MC_inst  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst_valid", {31'd0, IF_inst_valid}, 32'd0);
        chk("rst_inst", IF_inst, 32'd0);
        chk("rst_mc_req", {31'd0, MC_req}, 32'd0);
        chk("rst_mc_addr", MC_addr, 32'd0);
        chk("rst_ready", {31'd0, IF_ready}, 32'd1);
        rst = 1'b0;

        // Cold miss, controller latency 5.
        fetch(32'h0000_1000, 1'b0);
        serve(32'h0000_1000, 5);

        // Hit on the same address.
        fetch(32'h0000_1000, 1'b1);
        chk("hit_no_req", {31'd0, MC_req}, 32'd0);

        // Conflict: same index, different tag, then the original back again.
        fetch(32'h0000_1100, 1'b0);
        serve(32'h0000_1100, 3);
        fetch(32'h0000_1000, 1'b0);
        serve(32'h0000_1000, 2);

        // MC_done while idle must not disturb anything.
        MC_done = 1'b1;
        MC_inst = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        MC_done = 1'b0;
        chk("stray_done_no_pulse", {31'd0, IF_inst_valid}, 32'd0);
        chk("stray_done_no_req", {31'd0, MC_req}, 32'd0);

        // Flush during a miss, coincident with MC_done. The line must keep
        // 0x1000, so the next 0x1000 access has to hit.
        fetch(32'h0000_1100, 1'b0);
        chk("flush_pre_req", {31'd0, MC_req}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        clr     = 1'b1;
        MC_done = 1'b1;
        MC_inst = mem_word(32'h0000_1100);
        @(posedge clk);
        #1;
        clr     = 1'b0;
        MC_done = 1'b0;
        chk("flush_req", {31'd0, MC_req}, 32'd0);
        chk("flush_no_pulse", {31'd0, IF_inst_valid}, 32'd0);
        chk("flush_idle", {31'd0, IF_ready}, 32'd1);
        fetch(32'h0000_1000, 1'b1);
        chk("flush_hit_no_req", {31'd0, MC_req}, 32'd0);

        // Stall for 3 cycles in the middle of a miss.
        fetch(32'h0000_1004, 1'b0);
        @(posedge clk);
        #1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_req", {31'd0, MC_req}, 32'd1);
            chk("stall_addr", MC_addr, 32'h0000_1004);
            chk("stall_ready", {31'd0, IF_ready}, 32'd0);
            chk("stall_inst_hold", IF_inst, 32'h0050_0093);
        end
        rdy = 1'b1;
        serve(32'h0000_1004, 1);

        // Fill the rest of 0x1008..0x101C, then stream 8 hits back to back.
        for (int a = 32'h1008; a <= 32'h101C; a += 4) begin
            fetch(a, 1'b0);
            serve(a, 1);
        end
        IF_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            IF_pc = 32'h0000_1000 + 32'(i * 4);
            exp_q.push_back(mem_word(IF_pc));
            @(posedge clk);
            #1;
            chk("stream_pulse", {31'd0, IF_inst_valid}, 32'd1);
            $display("stream pc=0x%08h", 32'h0000_1000 + 32'(i * 4));
        end
        IF_valid = 1'b0;
        chk("stream_no_req", {31'd0, MC_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("stream_end", {31'd0, IF_inst_valid}, 32'd0);

        // Reset mid-miss, with MC_done in the same cycle. Afterwards every
        // line is invalid, so 0x1000 misses again.
        fetch(32'h0000_1100, 1'b0);
        rst     = 1'b1;
        MC_done = 1'b1;
        MC_inst = mem_word(32'h0000_1100);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        MC_done = 1'b0;
        chk("rst_miss_req", {31'd0, MC_req}, 32'd0);
        chk("rst_miss_addr", MC_addr, 32'd0);
        fetch(32'h0000_1000, 1'b0);
        serve(32'h0000_1000, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
